// File: rtl/pacman_move_controller.sv
// Pac-Man movement: latches the KEY direction, wall-checks one tile per tick,
// eats pellets through the shared map port and updates the char registers.
module pacman_move_controller #(
  parameter int MAP_WIDTH  = 21,
  parameter int MAP_HEIGHT = 23,
  parameter int TILE_SIZE  = 5,
  parameter int START_X    = 10,
  parameter int START_Y    = 17
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] pacman_controls,
  output logic       map_req,
  input  logic       map_grant,
  output logic [4:0] map_x,
  output logic [4:0] map_y,
  output logic       map_readwrite,
  output logic [2:0] map_data_out,
  input  logic [2:0] map_data_in,
  output logic [7:0] char_x,
  output logic [7:0] char_y,
  output logic [2:0] char_type,
  output logic       char_write,
  output logic [1:0] pacman_dir,
  output logic [9:0] score,
  output logic       busy
);
  typedef enum logic [2:0] {
    IDLE, REQ, RD_ADDR, RD_WAIT, CHECK, WR_TILE, WR_CHAR
  } state_t;

  localparam logic [4:0] X_MAX = 5'(MAP_WIDTH - 1);
  localparam logic [4:0] Y_MAX = 5'(MAP_HEIGHT - 1);
  localparam logic [7:0] TS    = 8'(TILE_SIZE);
  localparam logic [7:0] CX0   = 8'(START_X * TILE_SIZE);
  localparam logic [7:0] CY0   = 8'(START_Y * TILE_SIZE);

  state_t      state, next_state;
  logic [4:0]  tile_x, tile_y;
  logic [4:0]  tgt_x, tgt_y;
  logic [1:0]  want_dir, cand;
  logic        want_valid, moving, fallback;
  logic [7:0]  char_x_q, char_y_q;
  logic [7:0]  pix_x, pix_y;
  logic        is_wall, is_pellet, is_power, retry;
  logic [10:0] score_sum;

  always_comb begin
    tgt_x = tile_x;
    tgt_y = tile_y;
    case (cand)
      2'd0: tgt_x = (tile_x == X_MAX) ? 5'd0 : tile_x + 5'd1;
      2'd1: tgt_y = (tile_y == Y_MAX) ? 5'd0 : tile_y + 5'd1;
      2'd2: tgt_y = (tile_y == 5'd0) ? Y_MAX : tile_y - 5'd1;
      default: tgt_x = (tile_x == 5'd0) ? X_MAX : tile_x - 5'd1;
    endcase
  end

  assign is_wall   = (map_data_in == 3'd1);
  assign is_pellet = (map_data_in == 3'd2);
  assign is_power  = (map_data_in == 3'd3);
  // Only a fresh turn into a wall falls back to the current heading.
  assign retry = is_wall && !fallback && moving &&
                 (cand == want_dir) && (want_dir != pacman_dir);

  assign score_sum = {1'b0, score} + (is_power ? 11'd5 : 11'd1);
  assign pix_x     = 8'(tile_x) * TS;
  assign pix_y     = 8'(tile_y) * TS;

  always_ff @(posedge clock_50) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (tick && want_valid) next_state = REQ;
      REQ:     if (map_grant) next_state = RD_ADDR;
      RD_ADDR: next_state = RD_WAIT;
      RD_WAIT: next_state = CHECK;
      CHECK: begin
        if (retry)                       next_state = RD_ADDR;
        else if (is_wall)                next_state = IDLE;
        else if (is_pellet || is_power)  next_state = WR_TILE;
        else                             next_state = WR_CHAR;
      end
      WR_TILE: next_state = WR_CHAR;
      WR_CHAR: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    map_req       = 1'b0;
    map_readwrite = 1'b0;
    map_x         = 5'd0;
    map_y         = 5'd0;
    char_write    = 1'b0;
    unique case (state)
      REQ: map_req = 1'b1;
      RD_ADDR, RD_WAIT, CHECK: begin
        map_req = 1'b1;
        map_x   = tgt_x;
        map_y   = tgt_y;
      end
      WR_TILE: begin
        map_req       = 1'b1;
        map_readwrite = 1'b1;
        map_x         = tile_x;
        map_y         = tile_y;
      end
      WR_CHAR: char_write = 1'b1;
      default: ;
    endcase
  end

  assign busy         = (state != IDLE);
  assign map_data_out = 3'd0;
  assign char_type    = 3'd0;
  assign char_x       = (state == WR_CHAR) ? pix_x : char_x_q;
  assign char_y       = (state == WR_CHAR) ? pix_y : char_y_q;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      tile_x     <= 5'(START_X);
      tile_y     <= 5'(START_Y);
      char_x_q   <= CX0;
      char_y_q   <= CY0;
      pacman_dir <= 2'd0;
      moving     <= 1'b0;
      want_dir   <= 2'd0;
      want_valid <= 1'b0;
      score      <= 10'd0;
      cand       <= 2'd0;
      fallback   <= 1'b0;
    end else begin
      if (!(&pacman_controls)) begin
        want_valid <= 1'b1;
        priority case (1'b1)
          !pacman_controls[0]: want_dir <= 2'd0;
          !pacman_controls[1]: want_dir <= 2'd1;
          !pacman_controls[2]: want_dir <= 2'd2;
          default:             want_dir <= 2'd3;
        endcase
      end
      case (state)
        IDLE: begin
          if (tick && want_valid) begin
            cand     <= want_dir;
            fallback <= 1'b0;
          end
        end
        CHECK: begin
          if (retry) begin
            cand     <= pacman_dir;
            fallback <= 1'b1;
          end else if (is_wall) begin
            moving <= 1'b0;
          end else begin
            tile_x     <= tgt_x;
            tile_y     <= tgt_y;
            pacman_dir <= cand;
            moving     <= 1'b1;
            if (is_pellet || is_power)
              score <= (score_sum > 11'd1023) ? 10'd1023 : score_sum[9:0];
          end
        end
        WR_CHAR: begin
          char_x_q <= pix_x;
          char_y_q <= pix_y;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pacman_move_controller.sv
// Self-checking bench: tile-level move model, RAM model and per-cycle monitor.
module tb_pacman_move_controller;
  localparam int W  = 21;
  localparam int H  = 23;
  localparam int TS = 5;

  logic       clock_50 = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] pacman_controls = 4'hF;
  logic       map_grant = 1'b0;
  logic       map_req, map_readwrite, char_write, busy;
  logic [4:0] map_x, map_y;
  logic [2:0] map_data_out, map_data_in, char_type;
  logic [7:0] char_x, char_y;
  logic [1:0] pacman_dir;
  logic [9:0] score;

  pacman_move_controller dut (
    .clock_50(clock_50), .reset(reset), .tick(tick),
    .pacman_controls(pacman_controls),
    .map_req(map_req), .map_grant(map_grant),
    .map_x(map_x), .map_y(map_y), .map_readwrite(map_readwrite),
    .map_data_out(map_data_out), .map_data_in(map_data_in),
    .char_x(char_x), .char_y(char_y), .char_type(char_type),
    .char_write(char_write), .pacman_dir(pacman_dir),
    .score(score), .busy(busy)
  );

  always #10 clock_50 = ~clock_50;

  logic [2:0] tmap [0:31][0:31];
  logic [2:0] rdata = 3'd0;
  assign map_data_in = rdata;

  always @(posedge clock_50) begin
    rdata <= tmap[map_y][map_x];
    if (map_req && map_readwrite) tmap[map_y][map_x] = map_data_out;
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // tile-level model
  int mx = 10, my = 17, mdir = 0, mscore = 0, mwant = 0;
  bit mmoving = 0;

  // monitor expectations
  bit mon_en = 0;
  int cur_cx = 50, cur_cy = 85, nxt_cx = 50, nxt_cy = 85;
  int exp_wx = 0, exp_wy = 0, cw_cnt = 0, mw_cnt = 0, last_a = -1;
  int rd_x[$];
  int rd_y[$];

  always @(negedge clock_50) begin
    if (mon_en) begin
      chk(char_type == 3'd0, "char_type", int'(char_type), 0);
      if (char_write) begin
        cw_cnt++;
        chk(int'(char_x) == nxt_cx, "char_x_wr", int'(char_x), nxt_cx);
        chk(int'(char_y) == nxt_cy, "char_y_wr", int'(char_y), nxt_cy);
        chk(!map_req, "req_in_char_wr", int'(map_req), 0);
        cur_cx = nxt_cx;
        cur_cy = nxt_cy;
      end else begin
        chk(int'(char_x) == cur_cx, "char_x_hold", int'(char_x), cur_cx);
        chk(int'(char_y) == cur_cy, "char_y_hold", int'(char_y), cur_cy);
      end
      if (map_readwrite) begin
        mw_cnt++;
        chk(map_req, "wr_req", int'(map_req), 1);
        chk(int'(map_x) == exp_wx, "wr_x", int'(map_x), exp_wx);
        chk(int'(map_y) == exp_wy, "wr_y", int'(map_y), exp_wy);
        chk(map_data_out == 3'd0, "wr_data", int'(map_data_out), 0);
      end
      if (!busy)
        chk(!map_req && !map_readwrite && !char_write, "idle_quiet",
            int'({map_req, map_readwrite, char_write}), 0);
      if (!map_grant)
        chk(map_x == 5'd0 && map_y == 5'd0, "addr_before_grant",
            int'({map_x, map_y}), 0);
      if (map_req && map_grant && !map_readwrite && {map_x, map_y} != 10'd0 &&
          int'({map_x, map_y}) != last_a) begin
        rd_x.push_back(int'(map_x));
        rd_y.push_back(int'(map_y));
        last_a = int'({map_x, map_y});
      end
    end
  end

  task automatic step(input int x, input int y, input int d, output int tx, output int ty);
    tx = x;
    ty = y;
    case (d)
      0: tx = (x + 1) % W;
      1: ty = (y + 1) % H;
      2: ty = (y + H - 1) % H;
      default: tx = (x + W - 1) % W;
    endcase
  endtask

  task automatic set_keys(input logic [3:0] k);
    pacman_controls = k;
    if (!k[0]) mwant = 0;
    else if (!k[1]) mwant = 1;
    else if (!k[2]) mwant = 2;
    else mwant = 3;
    repeat (2) @(negedge clock_50);
  endtask

  task automatic do_reset(input string name);
    mon_en = 0;
    reset = 1'b1;
    map_grant = 1'b0;
    tick = 1'b0;
    repeat (3) @(negedge clock_50);
    chk(char_x == 8'd50, {name, "_char_x"}, int'(char_x), 50);
    chk(char_y == 8'd85, {name, "_char_y"}, int'(char_y), 85);
    chk(score == 10'd0, {name, "_score"}, int'(score), 0);
    chk(!map_req, {name, "_map_req"}, int'(map_req), 0);
    chk(!busy, {name, "_busy"}, int'(busy), 0);
    chk(!char_write, {name, "_char_write"}, int'(char_write), 0);
    chk(!map_readwrite && map_x == 0 && map_y == 0, {name, "_map_bus"},
        int'({map_readwrite, map_x, map_y}), 0);
    chk(pacman_dir == 2'd0, {name, "_dir"}, int'(pacman_dir), 0);
    reset = 1'b0;
    mx = 10; my = 17; mdir = 0; mscore = 0; mmoving = 0;
    cur_cx = 50; cur_cy = 85; nxt_cx = 50; nxt_cy = 85;
    @(negedge clock_50);
    mon_en = 1;
  endtask

  task automatic do_move(input int gdelay, input bit extra_tick, input string name);
    int tx, ty, cand, code, n, nrd, lat, nr;
    int ex_rx[2];
    int ex_ry[2];
    bit moves, wr;
    cand = mwant;
    step(mx, my, cand, tx, ty);
    ex_rx[0] = tx; ex_ry[0] = ty; ex_rx[1] = 0; ex_ry[1] = 0;
    nrd = 1;
    code = int'(tmap[ty][tx]);
    if (code == 1 && mmoving && mwant != mdir) begin
      cand = mdir;
      step(mx, my, cand, tx, ty);
      ex_rx[1] = tx; ex_ry[1] = ty;
      nrd = 2;
      code = int'(tmap[ty][tx]);
    end
    moves = (code != 1);
    wr = moves && (code == 2 || code == 3);
    lat = gdelay + 5 + (wr ? 1 : 0) + (nrd == 2 ? 3 : 0);
    nxt_cx = moves ? tx * TS : cur_cx;
    nxt_cy = moves ? ty * TS : cur_cy;
    exp_wx = tx; exp_wy = ty;
    cw_cnt = 0; mw_cnt = 0; last_a = -1;
    rd_x.delete(); rd_y.delete();

    tick = 1'b1;
    @(negedge clock_50);
    tick = 1'b0;
    n = 1;
    map_grant = (n > gdelay);
    while (!char_write && busy && n < 60) begin
      if (!map_grant) chk(map_req, {name, "_req_hold"}, int'(map_req), 1);
      tick = (extra_tick && n == 3);
      @(negedge clock_50);
      n++;
      map_grant = (n > gdelay);
    end
    tick = 1'b0;
    if (moves) begin
      chk(char_write, {name, "_char_write"}, int'(char_write), 1);
      chk(n == lat, {name, "_latency"}, n, lat);
    end else begin
      chk(!busy && !char_write, {name, "_stop"}, int'({busy, char_write}), 0);
    end
    repeat (3) @(negedge clock_50);
    map_grant = 1'b0;

    if (moves) begin
      mx = tx; my = ty; mdir = cand; mmoving = 1;
      if (code == 2) mscore = mscore + 1;
      if (code == 3) mscore = mscore + 5;
      if (mscore > 1023) mscore = 1023;
    end else begin
      mmoving = 0;
    end
    chk(cw_cnt == int'(moves), {name, "_char_writes"}, cw_cnt, int'(moves));
    chk(mw_cnt == int'(wr), {name, "_map_writes"}, mw_cnt, int'(wr));
    chk(rd_x.size() == nrd, {name, "_reads"}, rd_x.size(), nrd);
    nr = (rd_x.size() < nrd) ? rd_x.size() : nrd;
    for (int i = 0; i < nr; i++) begin
      chk(rd_x[i] == ex_rx[i], {name, "_read_x"}, rd_x[i], ex_rx[i]);
      chk(rd_y[i] == ex_ry[i], {name, "_read_y"}, rd_y[i], ex_ry[i]);
    end
    chk(int'(score) == mscore, {name, "_score"}, int'(score), mscore);
    chk(int'(pacman_dir) == mdir, {name, "_dir"}, int'(pacman_dir), mdir);
    chk(!busy, {name, "_idle_after"}, int'(busy), 0);
    if (wr) chk(tmap[ty][tx] == 3'd0, {name, "_cleared"}, int'(tmap[ty][tx]), 0);
  endtask

  initial begin
    int tx, ty;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        tmap[y][x] = 3'd0;

    do_reset("reset");

    tick = 1'b1;
    @(negedge clock_50);
    tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk(!busy, "tick_without_key", int'(busy), 0);
      @(negedge clock_50);
    end

    set_keys(4'b1110);
    do_move(0, 0, "empty");
    chk(char_x == 8'd55, "empty_px", int'(char_x), 55);
    chk(char_y == 8'd85, "empty_py", int'(char_y), 85);
    chk(score == 10'd0, "empty_score_lit", int'(score), 0);

    tmap[17][12] = 3'd2;
    do_move(0, 0, "pellet");
    chk(score == 10'd1, "pellet_score_lit", int'(score), 1);

    tmap[17][13] = 3'd3;
    do_move(0, 0, "power");
    chk(score == 10'd6, "power_score_lit", int'(score), 6);

    set_keys(4'b1011);
    tmap[16][13] = 3'd1;
    do_move(0, 0, "fallback");
    chk(char_x == 8'd70, "fallback_px", int'(char_x), 70);
    chk(pacman_dir == 2'd0, "fallback_dir_lit", int'(pacman_dir), 0);

    tmap[16][14] = 3'd1;
    tmap[17][15] = 3'd1;
    do_move(0, 0, "both_walls");
    chk(char_x == 8'd70, "both_walls_px", int'(char_x), 70);

    set_keys(4'b0111);
    for (int i = 0; i < 30 && mx != 0; i++) do_move(0, 0, "west");
    do_move(0, 0, "wrap");
    chk(char_x == 8'd100, "wrap_px", int'(char_x), 100);
    chk(char_y == 8'd85, "wrap_py", int'(char_y), 85);

    do_move(10, 1, "arb");
    chk(char_x == 8'd95, "arb_px", int'(char_x), 95);

    for (int i = 0; i < 206; i++) begin
      step(mx, my, mwant, tx, ty);
      tmap[ty][tx] = (i < 4) ? 3'd2 : 3'd3;
      do_move(0, 0, "eat");
    end
    chk(score == 10'd1020, "score_1020", int'(score), 1020);
    step(mx, my, mwant, tx, ty);
    tmap[ty][tx] = 3'd3;
    do_move(0, 0, "sat_power");
    chk(score == 10'd1023, "sat_power_lit", int'(score), 1023);
    step(mx, my, mwant, tx, ty);
    tmap[ty][tx] = 3'd2;
    do_move(0, 0, "sat_pellet");
    chk(score == 10'd1023, "sat_pellet_lit", int'(score), 1023);

    step(mx, my, mwant, tx, ty);
    tmap[ty][tx] = 3'd2;
    cw_cnt = 0; mw_cnt = 0;
    tick = 1'b1;
    @(negedge clock_50);
    tick = 1'b0;
    map_grant = 1'b1;
    repeat (2) @(negedge clock_50);
    do_reset("reset_mid");
    chk(cw_cnt == 0, "reset_mid_char_writes", cw_cnt, 0);
    chk(mw_cnt == 0, "reset_mid_map_writes", mw_cnt, 0);
    chk(tmap[ty][tx] == 3'd2, "reset_mid_pellet_kept", int'(tmap[ty][tx]), 2);
    repeat (4) @(negedge clock_50);
    chk(!busy && cw_cnt == 0, "reset_mid_quiet", int'(busy) + cw_cnt, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
